// File: rtl/rnn_pkg.sv
// rnn_pkg: state enum, address map and clamp helpers
// shared by the rnn_cell_engine slice.
package rnn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    MAC_X,
    MAC_H,
    STORE,
    COMMIT,
    D_INIT,
    D_MAC,
    OUT,
    DONE
  } state_t;

  localparam logic [11:0] CTRL   = 12'h000;
  localparam logic [11:0] RESULT = 12'h001;
  localparam logic [11:0] DBIAS  = 12'h002;
  localparam logic [11:0] X      = 12'h100;
  localparam logic [11:0] H      = 12'h200;
  localparam logic [11:0] B      = 12'h300;
  localparam logic [11:0] D      = 12'h400;
  localparam logic [11:0] WX     = 12'h800;
  localparam logic [11:0] WH     = 12'hC00;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  function automatic logic signed [63:0] clip(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Clamp to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return clip(v, lo, hi);
  endfunction

endpackage

// File: rtl/rnn_cell_engine_mac.sv
// rnn_mac: signed MAC with load and enable, registered acc.
// Ports: init/init_val load, en accumulates a*b into acc.
module rnn_mac
  import rnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic signed [ACC_W-1:0]  init_val,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (init) begin
      acc <= init_val;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine: bus-mapped Elman RNN step plus dense head.
// Ports: clk, rst_n, read/write strobes, addr, data_in, data_out.
module rnn_cell_engine
  import rnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int HIDDEN = 16,
  parameter int INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int MAXD  = (INPUTS > HIDDEN) ? INPUTS : HIDDEN;
  localparam int ACC_W = 2*DATA_W + $clog2(MAXD + HIDDEN + 1);
  localparam int XW    = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int HW    = $clog2(HIDDEN);
  localparam int NWX   = INPUTS * HIDDEN;
  localparam int NWH   = HIDDEN * HIDDEN;
  localparam int WXW   = $clog2(NWX);
  localparam int WHW   = $clog2(NWH);

  localparam logic [XW-1:0] LAST_I = XW'(INPUTS - 1);
  localparam logic [HW-1:0] LAST_H = HW'(HIDDEN - 1);

  logic signed [DATA_W-1:0] x_mem  [INPUTS];
  logic signed [DATA_W-1:0] h_mem  [HIDDEN];
  logic signed [DATA_W-1:0] hs_mem [HIDDEN];
  logic signed [DATA_W-1:0] b_mem  [HIDDEN];
  logic signed [DATA_W-1:0] d_mem  [HIDDEN];
  logic signed [DATA_W-1:0] wx_mem [NWX];
  logic signed [DATA_W-1:0] wh_mem [NWH];
  logic signed [DATA_W-1:0] dbias;
  logic signed [DATA_W-1:0] result;

  state_t        state;
  logic [XW-1:0] i_cnt;
  logic [HW-1:0] j_cnt;
  logic [HW-1:0] k_cnt;
  logic          busy;
  logic          done;

  assign busy = !(state == IDLE || state == DONE);
  assign done = (state == DONE);

  logic [11:0] a12;
  logic        sel_ctrl, sel_res, sel_dbias;
  logic        sel_x, sel_h, sel_b, sel_d;
  logic        sel_wx, sel_wh;
  logic [XW-1:0]  x_idx;
  logic [HW-1:0]  h_idx;
  logic [WXW-1:0] wx_a;
  logic [WHW-1:0] wh_a;
  logic signed [DATA_W-1:0] wdata;
  logic unused_bits;

  assign a12       = addr[11:0];
  assign sel_ctrl  = (a12 == CTRL);
  assign sel_res   = (a12 == RESULT);
  assign sel_dbias = (a12 == DBIAS);
  assign sel_x  = (a12[11:8] == X[11:8]) && (a12[7:0] < 8'(INPUTS));
  assign sel_h  = (a12[11:8] == H[11:8]) && (a12[7:0] < 8'(HIDDEN));
  assign sel_b  = (a12[11:8] == B[11:8]) && (a12[7:0] < 8'(HIDDEN));
  assign sel_d  = (a12[11:8] == D[11:8]) && (a12[7:0] < 8'(HIDDEN));
  assign sel_wx = (a12[11:10] == WX[11:10])
                && ({1'b0, a12[9:0]} < 11'(NWX));
  assign sel_wh = (a12[11:10] == WH[11:10])
                && ({1'b0, a12[9:0]} < 11'(NWH));
  assign x_idx  = a12[XW-1:0];
  assign h_idx  = a12[HW-1:0];
  assign wx_a   = a12[WXW-1:0];
  assign wh_a   = a12[WHW-1:0];
  assign wdata  = data_in[DATA_W-1:0];
  assign unused_bits = ^{addr[31:12], data_in};

  // Weight indices for the neuron currently being evaluated.
  logic [WXW-1:0] wx_idx;
  logic [WHW-1:0] wh_idx;

  assign wx_idx = WXW'(i_cnt) * WXW'(HIDDEN) + WXW'(j_cnt);
  assign wh_idx = WHW'(k_cnt) * WHW'(HIDDEN) + WHW'(j_cnt);

  logic                     mac_init;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  init_val;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [DATA_W-1:0] h_next;
  logic signed [DATA_W-1:0] y_next;

  always_comb begin
    mac_init = 1'b0;
    mac_en   = 1'b0;
    init_val = '0;
    mac_a    = '0;
    mac_b    = '0;
    unique case (state)
      INIT: begin
        mac_init = 1'b1;
        init_val = ACC_W'(b_mem[j_cnt]) <<< FRAC;
      end
      MAC_X: begin
        mac_en = 1'b1;
        mac_a  = wx_mem[wx_idx];
        mac_b  = x_mem[i_cnt];
      end
      MAC_H: begin
        mac_en = 1'b1;
        mac_a  = wh_mem[wh_idx];
        mac_b  = h_mem[k_cnt];
      end
      D_INIT: begin
        mac_init = 1'b1;
        init_val = ACC_W'(dbias) <<< FRAC;
      end
      D_MAC: begin
        mac_en = 1'b1;
        mac_a  = d_mem[j_cnt];
        mac_b  = h_mem[j_cnt];
      end
      default: ;
    endcase
  end

  rnn_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (mac_init),
    .init_val (init_val),
    .en       (mac_en),
    .a        (mac_a),
    .b        (mac_b),
    .acc      (acc)
  );

  // hardtanh for the hidden state, plain saturation for y
  assign acc_sh = acc >>> FRAC;
  assign h_next = DATA_W'(clip(64'(acc_sh),
                               -(64'sd1 <<< FRAC),
                               64'sd1 <<< FRAC));
  assign y_next = DATA_W'(sat(64'(acc_sh), DATA_W));

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_ctrl: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done;
      end
      sel_res:   rd_data = 32'(result);
      sel_dbias: rd_data = 32'(dbias);
      sel_x:     rd_data = 32'(x_mem[x_idx]);
      sel_h:     rd_data = 32'(h_mem[h_idx]);
      sel_b:     rd_data = 32'(b_mem[h_idx]);
      sel_d:     rd_data = 32'(d_mem[h_idx]);
      sel_wx:    rd_data = 32'(wx_mem[wx_a]);
      sel_wh:    rd_data = 32'(wh_mem[wh_a]);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_cnt    <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      dbias    <= '0;
      result   <= '0;
      data_out <= '0;
      for (int n = 0; n < INPUTS; n++) x_mem[n] <= '0;
      for (int n = 0; n < HIDDEN; n++) begin
        h_mem[n]  <= '0;
        hs_mem[n] <= '0;
        b_mem[n]  <= '0;
        d_mem[n]  <= '0;
      end
      for (int n = 0; n < NWX; n++) wx_mem[n] <= '0;
      for (int n = 0; n < NWH; n++) wh_mem[n] <= '0;
    end else begin
      if (read) data_out <= rd_data;

      unique case (state)
        INIT: begin
          i_cnt <= '0;
          k_cnt <= '0;
          state <= MAC_X;
        end
        MAC_X: begin
          if (i_cnt == LAST_I) state <= MAC_H;
          else i_cnt <= i_cnt + 1'b1;
        end
        MAC_H: begin
          if (k_cnt == LAST_H) state <= STORE;
          else k_cnt <= k_cnt + 1'b1;
        end
        STORE: begin
          hs_mem[j_cnt] <= h_next;
          if (j_cnt == LAST_H) begin
            j_cnt <= '0;
            state <= COMMIT;
          end else begin
            j_cnt <= j_cnt + 1'b1;
            state <= INIT;
          end
        end
        COMMIT: begin
          for (int n = 0; n < HIDDEN; n++) h_mem[n] <= hs_mem[n];
          state <= D_INIT;
        end
        D_INIT: state <= D_MAC;
        D_MAC: begin
          if (j_cnt == LAST_H) state <= OUT;
          else j_cnt <= j_cnt + 1'b1;
        end
        OUT: begin
          result <= y_next;
          state  <= DONE;
        end
        default: ;
      endcase

      // Only reachable in IDLE/DONE, so it never races the FSM above.
      if (write && !busy) begin
        unique case (1'b1)
          sel_ctrl: begin
            if (data_in[CTRL_CLEAR]) begin
              for (int n = 0; n < HIDDEN; n++) begin
                h_mem[n]  <= '0;
                hs_mem[n] <= '0;
              end
              state <= IDLE;
            end
            if (data_in[CTRL_START]) begin
              j_cnt <= '0;
              state <= INIT;
            end
          end
          sel_dbias: dbias          <= wdata;
          sel_x:     x_mem[x_idx]   <= wdata;
          sel_h:     h_mem[h_idx]   <= wdata;
          sel_b:     b_mem[h_idx]   <= wdata;
          sel_d:     d_mem[h_idx]   <= wdata;
          sel_wx:    wx_mem[wx_a]   <= wdata;
          sel_wh:    wh_mem[wh_a]   <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rnn_cell_engine.sv
// tb_rnn_cell_engine: directed vectors with a read scoreboard
// and cycle-exact done timing checks.
module tb_rnn_cell_engine;

  localparam int HN = 16;
  localparam int IN = 4;
  localparam int L  = HN*(IN+HN+2) + HN + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  rnn_cell_engine #(
    .DATA_W (16),
    .FRAC   (8),
    .HIDDEN (HN),
    .INPUTS (IN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  logic poll = 1'b0;
  logic rd_q = 1'b0;

  // status polling reads bypass the scoreboard
  always @(posedge clk) rd_q <= read && !poll;

  always @(negedge clk) begin
    exp_t e;
    if (rd_q) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: got %h with no expected value",
                 data_out);
      end else begin
        e = sb.pop_front();
        if (data_out === e.exp) passes++;
        else $display("FAIL %s: got %h expected %h",
                      e.name, data_out, e.exp);
      end
    end
  end

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    exp_t e;
    @(negedge clk);
    read = 1'b1;
    addr = a;
    e.name = nm;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    read = 1'b1;
    write = 1'b1;
    addr = a;
    data_in = d;
    e.name = nm;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  // Start, then poll STATUS every cycle. Both busy and done are
  // seen through the 1-cycle read path, so done shows at L+1.
  task automatic run_step(input logic [31:0] ctrl,
                          input int inject_at, input string nm);
    int cyc;
    bit seen;
    wr(32'h0, ctrl);
    poll = 1'b1;
    read = 1'b1;
    addr = 32'h0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (data_out[1]) seen = 1'b1;
      if (cyc == inject_at) begin
        write = 1'b1;
        addr = 32'h800;
        data_in = 32'h1234;
      end else if (cyc == inject_at + 1) begin
        addr = 32'h0;
        data_in = 32'h1;
      end else if (cyc == inject_at + 2) begin
        write = 1'b0;
      end
    end
    read = 1'b0;
    poll = 1'b0;
    write = 1'b0;
    check(nm, cyc, L + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    rd(32'h000, 32'h0, "rst_status");
    rd(32'h001, 32'h0, "rst_result");
    rd(32'h200, 32'h0, "rst_h0");
    rd(32'h800, 32'h0, "rst_wx00");
    rd(32'h003, 32'h0, "unmapped_003");
    rd(32'h104, 32'h0, "x_out_of_range");
    rd(32'h210, 32'h0, "h_out_of_range");

    // bias-only step
    for (int j = 0; j < HN; j++) begin
      wr(32'h300 + j, 32'h0080);
      wr(32'h400 + j, 32'h0100);
    end
    wr(32'h002, 32'h0);
    run_step(32'h1, -10, "lat_bias");
    for (int j = 0; j < HN; j++)
      rd(32'h200 + j, 32'h80, $sformatf("bias_h%0d", j));
    rd(32'h001, 32'h800, "bias_result");
    rd(32'h000, 32'h2, "status_done");

    // clear_h drops done and h but keeps RESULT
    wr(32'h000, 32'h2);
    rd(32'h200, 32'h0, "clear_h0");
    rd(32'h000, 32'h0, "clear_status");
    rd(32'h001, 32'h800, "clear_keeps_result");

    // writes and start while busy are ignored
    run_step(32'h1, 50, "lat_busy_inject");
    rd(32'h800, 32'h0, "busy_wx_ignored");
    rd(32'h001, 32'h800, "busy_result");

    // reset mid-run
    wr(32'h000, 32'h1);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'h000, 32'h0, "midrst_status");
    rd(32'h001, 32'h0, "midrst_result");

    // hardtanh clip, positive then negative
    for (int j = 0; j < HN; j++) begin
      wr(32'h800 + j, 32'h0400);
      wr(32'h400 + j, 32'h0100);
    end
    wr(32'h100, 32'h0100);
    run_step(32'h1, -10, "lat_clip_pos");
    for (int j = 0; j < HN; j++)
      rd(32'h200 + j, 32'h100, $sformatf("clip_pos_h%0d", j));
    rd(32'h001, 32'h1000, "clip_pos_result");
    rdwr(32'h100, 32'hFC00, 32'h100, "rdwr_pre_value");
    rd(32'h100, 32'hFFFFFC00, "rdwr_post_value");
    run_step(32'h1, -10, "lat_clip_neg");
    for (int j = 0; j < HN; j++)
      rd(32'h200 + j, 32'hFFFFFF00, $sformatf("clip_neg_h%0d", j));
    rd(32'h001, 32'hFFFFF000, "clip_neg_result");

    // double buffering: h'[j] = h[(j+1)%H]
    do_reset();
    for (int j = 0; j < HN; j++)
      wr(32'hC00 + ((j + 1) % HN) * HN + j, 32'h0100);
    wr(32'h200, 32'h0010);
    run_step(32'h1, -10, "lat_dbuf1");
    run_step(32'h1, -10, "lat_dbuf2");
    for (int j = 0; j < HN; j++)
      rd(32'h200 + j, (j == HN - 2) ? 32'h10 : 32'h0,
         $sformatf("dbuf_h%0d", j));

    // dense head saturation
    do_reset();
    for (int j = 0; j < HN; j++) begin
      wr(32'h400 + j, 32'h7FFF);
      wr(32'h200 + j, 32'h0100);
      wr(32'hC00 + j * HN + j, 32'h0100);
    end
    run_step(32'h1, -10, "lat_sat_pos");
    rd(32'h001, 32'h00007FFF, "sat_pos_result");
    rd(32'h205, 32'h100, "sat_h5_kept");
    for (int j = 0; j < HN; j++)
      wr(32'h400 + j, 32'h8001);
    run_step(32'h1, -10, "lat_sat_neg");
    rd(32'h001, 32'hFFFF8000, "sat_neg_result");

    // start with clear_h: runs from h = 0
    run_step(32'h3, -10, "lat_start_clear");
    rd(32'h001, 32'h0, "start_clear_result");
    rd(32'h200, 32'h0, "start_clear_h0");

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rnn_cell_engine.md
# rnn_cell_engine

Parametrised Elman RNN step engine with an integrated dense output head, exposed as a memory-mapped slave on the processor bus. Software loads weights, biases, input vector and hidden state, then writes a start bit. The engine computes one time step, h' = hardtanh(Wxᵀx + Whᵀh + b), followed by y = dᵀh' + dense_bias, using a single sequential MAC. It supersedes the fixed 16-hidden/4-input RNN top-level with generic dimensions, double-buffered hidden state, saturation and status reporting.

## Interface
- DATA_W, 16: signed fixed-point word width for all weights, activations and results.
- FRAC, 8: fractional bits; 1.0 = 1<<FRAC.
- HIDDEN, 16: hidden size H, 2..32.
- INPUTS, 4: input size I, 1..32.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- read  in  1  read strobe.
- write  in  1  write strobe.
- addr  in  32  word address; only addr[11:0] is decoded.
- data_in  in  32  write data; the low DATA_W bits are used.
- data_out  out  32  registered read data, sign-extended from DATA_W; reset value 0.

## Operation
- Address map (word offsets):
  - 0x000 CTRL/STATUS. Write: bit0 = start, bit1 = clear_h. Read: bit0 = busy, bit1 = done.
  - 0x001 RESULT: y, read-only.
  - 0x002 DENSE_BIAS.
  - 0x100+i x[i].
  - 0x200+j h[j].
  - 0x300+j b[j].
  - 0x400+j d[j].
  - 0x800+i·H+j Wx[i][j].
  - 0xC00+k·H+j Wh[k][j].
  - Unmapped or out-of-range reads return 0; writes to them are ignored.
- FSM states: IDLE, INIT, MAC_X, MAC_H, STORE, COMMIT, D_INIT, D_MAC, OUT, DONE. busy = 1 in every state except IDLE and DONE.
- Neuron loop, for j = 0..H-1:
  - INIT: acc = b[j]<<FRAC.
  - MAC_X: acc += Wx[i][j]·x[i], one i per cycle.
  - MAC_H: acc += Wh[k][j]·h[k], one k per cycle; h here is the old state.
  - STORE: h_shadow[j] = clip(acc>>>FRAC, -(1<<FRAC), +(1<<FRAC)).
- COMMIT copies h_shadow into h in one cycle. Neuron j therefore never sees new values of other neurons.
- Dense head:
  - D_INIT: acc = dense_bias<<FRAC.
  - D_MAC: acc += d[j]·h[j] for each j.
  - OUT: RESULT = saturate(acc>>>FRAC) to the signed DATA_W range.
- Accumulator width is 2·DATA_W + clog2(max(I,H)+H+1), which cannot overflow internally. Shifts are arithmetic (truncation toward −∞).
- clear_h zeroes all h[j] and h_shadow[j] in one cycle. If start and clear_h are written together, clear applies first and the step runs from h = 0.
- Start while in DONE: the engine starts again and done clears.
- While busy:
  - Writes to every region, and the start and clear_h bits, are ignored.
  - Reads are permitted. The h region returns pre-COMMIT values until COMMIT.
- Read and write in the same cycle to the same address: the write takes effect, and data_out carries the pre-write value.
- Reset (any state): FSM goes to IDLE; all storage, RESULT, data_out and status go to 0.

## Timing
- Read latency is 1 cycle: data_out is valid the cycle after read is high and holds until the next read.
- Writes take effect at the clock edge where write is high.
- busy rises the cycle after an accepted start.
- done rises exactly L = H·(I+H+2) + H + 3 cycles after busy rises. Defaults give L = 371.
- done and RESULT hold until the next accepted start, a clear_h write (clears done only), or reset.
- No backpressure signal exists; software polls STATUS.

## Structure
- Package rnn_pkg holds:
  - The state enum.
  - Region base constants: CTRL, RESULT, DBIAS, X, H, B, D, WX, WH.
  - CTRL bit positions.
  - A saturate/clip function parametrised by width.
- Sub-module rnn_mac:
  - Signed multiply-accumulate with init, accumulate-enable and a registered accumulator.
  - Parametrised on DATA_W and ACC_W.
  - Shared by the recurrent and dense phases.
- Parameter and state storage are register arrays, so reset-to-zero is required.

## Test plan
- Reset, then read 0x000, 0x001, 0x200 and 0x800 → each returns 0x00000000.
- All weights 0, b[j] = 0x0080, d[j] = 0x0100, DENSE_BIAS = 0, start → done after exactly 371 cycles; each h[j] = 0x0080; RESULT = 0x00000800.
- Clip check with Wx[0][j] = 0x0400:
  - x[0] = 0x0100 → every h[j] = 0x0100.
  - x[0] = 0xFC00 → every h[j] = 0xFFFFFF00 on read.
- Double buffering: Wh[(j+1)%H][j] = 0x0100, all else 0, h = [0x0010, 0, …], two starts → h[H-2] = 0x0010 and all other h[j] = 0. A single-buffered implementation fails this check.
- Busy behaviour: during busy, write Wx[0][0] = 0x1234 and a start → neither takes effect and done timing is unchanged. Assert rst_n = 0 at cycle 100 → the next reads of STATUS and RESULT return 0.
- Dense saturation: d[j] = 0x7FFF, h[j] = 0x0100 preloaded, Wh = I·1.0, b = 0 → RESULT = 0x00007FFF. Negating all d[j] gives RESULT = 0xFFFF8000.
